in_sync_period_meter: RTL

Measures the period of the filtered, synchronized input produced by the input-synchronizer stage, in `clkm` cycles. Detects rising edges of `in_sync`, rejects edges arriving too soon, and publishes each accepted period with a one-cycle strobe. Flags loss of input via timeout. Sits directly downstream of the synchronizer and feeds the DPWM control path, which uses the measured period for duty and phase computation.

---
 rtl/in_sync_meter_pkg.sv | 7 +
 rtl/sync_rise_detect.sv | 14 +
 rtl/in_sync_period_meter.sv | 93 +++++++++
 3 files changed

// File: rtl/in_sync_meter_pkg.sv
// in_sync_meter_pkg: shared state encoding and default constants for in_sync_period_meter.
package in_sync_meter_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_FIRST, MEASURE, TIMEOUT} state_e;
  localparam int CNT_W_DEF = 16;
  localparam int MIN_PERIOD_DEF = 4;
  localparam int AVG_SHIFT = 2;
endpackage

// File: rtl/sync_rise_detect.sv
// sync_rise_detect: registers in_sync and flags its rising edge; prev_r resets high so a
// high input at reset release is not taken as an edge.
module sync_rise_detect (
  input  logic clkm,
  input  logic reset,
  input  logic in_sync,
  output logic rise
);
  logic prev_r;
  always_ff @(posedge clkm or negedge reset)
    if (!reset) prev_r <= 1'b1;
    else prev_r <= in_sync;
  assign rise = in_sync & ~prev_r;
endmodule

// File: rtl/in_sync_period_meter.sv
// in_sync_period_meter: measures in_sync rising-edge period in clkm cycles with reject/timeout.
// Optional running average output enabled by defining PERIOD_AVG_EN.
module in_sync_period_meter #(
  parameter int CNT_W = in_sync_meter_pkg::CNT_W_DEF,
  parameter int MIN_PERIOD = in_sync_meter_pkg::MIN_PERIOD_DEF,
  parameter int TIMEOUT = 2**CNT_W-1
) (
  input  logic             clkm,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_sync,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             reject,
  output logic             timeout,
`ifdef PERIOD_AVG_EN
  output logic [CNT_W-1:0] period_avg,
`endif
  output logic             locked
);
  import in_sync_meter_pkg::*;
  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT-1);
  state_e state;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic rise;
  sync_rise_detect u_rise (.clkm(clkm), .reset(reset), .in_sync(in_sync), .rise(rise));
  assign cnt_inc = cnt + CNT_W'(1);
`ifdef PERIOD_AVG_EN
  logic signed [CNT_W:0] avg_diff;
  logic [CNT_W-1:0] avg_next;
  // The difference needs one extra bit so a falling period shifts arithmetically.
  assign avg_diff = $signed({1'b0, cnt_inc}) - $signed({1'b0, period_avg});
  assign avg_next = period_avg + CNT_W'(avg_diff >>> AVG_SHIFT);
`endif
  always_ff @(posedge clkm or negedge reset)
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      edge_pulse   <= 1'b0;
      period_valid <= 1'b0;
      reject       <= 1'b0;
      timeout      <= 1'b0;
      locked       <= 1'b0;
`ifdef PERIOD_AVG_EN
      period_avg   <= '0;
`endif
    end else begin
      edge_pulse   <= rise;
      period_valid <= 1'b0;
      reject       <= 1'b0;
      if (!enable) begin
        state   <= IDLE;
        cnt     <= '0;
        timeout <= 1'b0;
        locked  <= 1'b0;
      end else
        case (state)
          IDLE: state <= WAIT_FIRST;
          WAIT_FIRST:
            if (rise) begin
              state <= MEASURE;
              cnt   <= '0;
            end
          MEASURE:
            if (rise && cnt_inc >= MIN_V) begin
              period       <= cnt_inc;
              period_valid <= 1'b1;
              locked       <= 1'b1;
              cnt          <= '0;
`ifdef PERIOD_AVG_EN
              period_avg   <= locked ? avg_next : cnt_inc;
`endif
            end else if (cnt == TO_M1) begin
              state   <= in_sync_meter_pkg::TIMEOUT;
              timeout <= 1'b1;
              locked  <= 1'b0;
            end else begin
              cnt    <= cnt_inc;
              reject <= rise;
            end
          in_sync_meter_pkg::TIMEOUT:
            if (rise) begin
              state   <= MEASURE;
              cnt     <= '0;
              timeout <= 1'b0;
            end
          default: state <= IDLE;
        endcase
    end
endmodule
